// File: rtl/bridge_pkg.sv
// Shared definitions for the drawbridge: state encodings, actuator bundle
// and the Moore output decode used by the sequencer.
package bridge_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WARN  = 3'd1;
    localparam logic [2:0] ST_CLEAR = 3'd2;
    localparam logic [2:0] ST_RAISE = 3'd3;
    localparam logic [2:0] ST_OPEN  = 3'd4;
    localparam logic [2:0] ST_LOWER = 3'd5;
    localparam logic [2:0] ST_FAULT = 3'd6;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        WARN  = ST_WARN,
        CLEAR = ST_CLEAR,
        RAISE = ST_RAISE,
        OPEN  = ST_OPEN,
        LOWER = ST_LOWER,
        FAULT = ST_FAULT
    } state_t;

    // Actuator payload driven by the sequencer.
    typedef struct packed {
        logic barrier;
        logic alert;
        logic motor_up;
        logic motor_down;
        logic bridge_open;
        logic fault;
    } act_t;

    // Moore decode of a state; unused encodings look like FAULT (motors off).
    function automatic act_t decode(input state_t s);
        act_t a;
        a = '{barrier: OFF, alert: OFF, motor_up: OFF, motor_down: OFF,
              bridge_open: OFF, fault: OFF};
        case (s)
            IDLE: ;
            WARN, CLEAR: begin
                a.alert   = ON;
                a.barrier = ON;
            end
            RAISE: begin
                a.alert    = ON;
                a.barrier  = ON;
                a.motor_up = ON;
            end
            OPEN: begin
                a.alert       = ON;
                a.barrier     = ON;
                a.bridge_open = ON;
            end
            LOWER: begin
                a.alert      = ON;
                a.barrier    = ON;
                a.motor_down = ON;
            end
            default: begin
                a.alert   = ON;
                a.barrier = ON;
                a.fault   = ON;
            end
        endcase
        return a;
    endfunction

endpackage

// File: rtl/car_counter.sv
// Saturating up/down counter of cars on the deck.
//   clk, rst_n : clock, async active-low reset
//   up, down   : one-cycle pulses; both together leave the count unchanged
//   count      : registered car count, saturates at 0 and 2^CNT_W-1
//   empty      : registered flag, high when count is 0
module car_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up,
    input  logic             down,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_next;

    // Next count with saturation at both ends.
    always_comb begin
        count_next = count;
        if (up && !down && count != CNT_MAX) begin
            count_next = count + CNT_W'(1);
        end else if (down && !up && count != '0) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            empty <= 1'b1;
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/bridge_sequencer.sv
// Drawbridge lift-cycle sequencer: warns traffic, closes the barrier, waits
// for an empty deck, raises and lowers the span with limit-switch handshakes
// and timeout supervision.
//   i_clk, i_reset             : clock, async active-low reset
//   i_carIn, i_carOut          : car entry / exit pulses
//   i_boatClose, i_boatHere    : boat approach / presence levels
//   i_bridgeUp, i_bridgeDown   : upper / lower limit switches
//   o_carBarrier, o_alert      : road barrier and warning
//   o_motorUp, o_motorDown     : lift motor drive
//   o_bridgeOpen, o_fault      : river open, sticky fault
//   o_state, o_carCount        : state encoding, cars on deck
module bridge_sequencer
    import bridge_pkg::*;
#(
    parameter int unsigned ALERT_CYCLES  = 8,
    parameter int unsigned MOTOR_TIMEOUT = 32,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_carIn,
    input  logic             i_carOut,
    input  logic             i_boatClose,
    input  logic             i_boatHere,
    input  logic             i_bridgeUp,
    input  logic             i_bridgeDown,
    output logic             o_carBarrier,
    output logic             o_alert,
    output logic             o_motorUp,
    output logic             o_motorDown,
    output logic             o_bridgeOpen,
    output logic             o_fault,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_carCount
);

    localparam int unsigned TMR_MAX = (ALERT_CYCLES > MOTOR_TIMEOUT) ? ALERT_CYCLES : MOTOR_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] WARN_LAST  = TMR_W'(ALERT_CYCLES - 1);
    localparam logic [TMR_W-1:0] MOTOR_LAST = TMR_W'(MOTOR_TIMEOUT - 1);

    state_t           state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    act_t             act, act_next;
    logic             boat_req;
    logic             deck_empty;

    car_counter #(.CNT_W(CNT_W)) u_car_counter (
        .clk   (i_clk),
        .rst_n (i_reset),
        .up    (i_carIn),
        .down  (i_carOut),
        .count (o_carCount),
        .empty (deck_empty)
    );

    // Next state, timer and actuator values; actuators are decoded from the
    // next state so they are registered alongside the state itself.
    always_comb begin
        state_next = state;
        timer_next = timer;
        boat_req   = i_boatClose | i_boatHere;

        case (state)
            IDLE:  if (boat_req) state_next = WARN;
            WARN: begin
                if (!boat_req)               state_next = IDLE;
                else if (timer == WARN_LAST) state_next = CLEAR;
            end
            CLEAR: begin
                if (!boat_req)       state_next = IDLE;
                else if (deck_empty) state_next = RAISE;
            end
            RAISE: begin
                if (i_bridgeUp)               state_next = OPEN;
                else if (timer == MOTOR_LAST) state_next = FAULT;
            end
            OPEN:  if (!boat_req) state_next = LOWER;
            LOWER: begin
                if (i_boatHere)               state_next = RAISE;
                else if (i_bridgeDown)        state_next = IDLE;
                else if (timer == MOTOR_LAST) state_next = FAULT;
            end
            FAULT:   state_next = FAULT;
            default: state_next = FAULT;
        endcase

        // Contradictory limit switches override everything.
        if (state != FAULT && i_bridgeUp && i_bridgeDown) begin
            state_next = FAULT;
        end

        // Timer restarts on any state change (LOWER->RAISE included).
        if (state_next != state) begin
            timer_next = '0;
        end else if (state == WARN || state == RAISE || state == LOWER) begin
            timer_next = timer + TMR_W'(1);
        end

        act_next = decode(state_next);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            timer <= '0;
            act   <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            act   <= act_next;
        end
    end

    assign o_carBarrier = act.barrier;
    assign o_alert      = act.alert;
    assign o_motorUp    = act.motor_up;
    assign o_motorDown  = act.motor_down;
    assign o_bridgeOpen = act.bridge_open;
    assign o_fault      = act.fault;
    assign o_state      = state;

endmodule

// File: tb/tb_bridge_sequencer.sv
// Directed self-checking bench for bridge_sequencer (default parameters).
module tb_bridge_sequencer;
    import bridge_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_in = 1'b0, car_out = 1'b0;
    logic       boat_close = 1'b0, boat_here = 1'b0;
    logic       br_up = 1'b0, br_down = 1'b0;
    logic       barrier, alert, motor_up, motor_down, bridge_open, fault;
    logic [2:0] st;
    logic [3:0] cnt;

    int total = 0;
    int bad   = 0;

    bridge_sequencer #(.ALERT_CYCLES(8), .MOTOR_TIMEOUT(32), .CNT_W(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_carIn      (car_in),
        .i_carOut     (car_out),
        .i_boatClose  (boat_close),
        .i_boatHere   (boat_here),
        .i_bridgeUp   (br_up),
        .i_bridgeDown (br_down),
        .o_carBarrier (barrier),
        .o_alert      (alert),
        .o_motorUp    (motor_up),
        .o_motorDown  (motor_down),
        .o_bridgeOpen (bridge_open),
        .o_fault      (fault),
        .o_state      (st),
        .o_carCount   (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        {car_in, car_out, boat_close, boat_here, br_up, br_down} = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_in();
        car_in = 1'b1; tick(1); car_in = 1'b0; tick(1);
    endtask

    task automatic pulse_out();
        car_out = 1'b1; tick(1); car_out = 1'b0; tick(1);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_state", int'(st), 0);
        check("rst_outs", int'({barrier, alert, motor_up, motor_down, bridge_open, fault}), 0);
        check("rst_count", int'(cnt), 0);

        // Normal cycle
        boat_close = 1'b1;
        tick(1);
        check("n_warn", int'(st), 1);
        check("n_warn_outs", int'({barrier, alert, motor_up}), 3'b110);
        tick(7);
        check("n_warn_last", int'(st), 1);
        tick(1);
        check("n_clear", int'(st), 2);
        tick(1);
        check("n_raise", int'(st), 3);
        check("n_motor_up", int'(motor_up), 1);
        tick(4);
        check("n_raise_5", int'(st), 3);
        br_up = 1'b1;
        tick(1);
        check("n_open", int'(st), 4);
        check("n_open_outs", int'({bridge_open, motor_up, alert}), 3'b101);
        br_up = 1'b0; boat_close = 1'b0;
        tick(1);
        check("n_lower", int'(st), 5);
        check("n_motor_dn", int'({motor_up, motor_down, alert}), 3'b011);
        tick(4);
        br_down = 1'b1;
        tick(1);
        check("n_idle", int'(st), 0);
        check("n_idle_alert", int'(alert), 0);
        br_down = 1'b0;

        // Cars on deck, then motor timeout in RAISE
        do_reset();
        pulse_in(); pulse_in(); pulse_in();
        check("c_count3", int'(cnt), 3);
        boat_close = 1'b1;
        tick(9);
        check("c_clear", int'(st), 2);
        tick(1);
        pulse_out();
        check("c_count2", int'(cnt), 2);
        check("c_hold2", int'(st), 2);
        pulse_out();
        check("c_count1", int'(cnt), 1);
        car_out = 1'b1; tick(1); car_out = 1'b0;
        check("c_count0", int'(cnt), 0);
        check("c_hold0", int'(st), 2);
        tick(1);
        check("c_raise", int'(st), 3);
        tick(31);
        check("t_raise_32", int'(st), 3);
        tick(1);
        check("t_fault", int'(st), 6);
        check("t_fault_outs", int'({motor_up, motor_down, fault, alert, barrier}), 5'b00111);
        boat_close = 1'b0;
        tick(5);
        check("t_fault_sticky", int'({st, fault}), {3'd6, 1'b1});

        // Counter edges
        do_reset();
        pulse_out();
        check("k_floor", int'(cnt), 0);
        pulse_in();
        car_in = 1'b1; car_out = 1'b1; tick(1); car_in = 1'b0; car_out = 1'b0;
        check("k_both", int'(cnt), 1);
        car_in = 1'b1; tick(16); car_in = 1'b0;
        check("k_sat", int'(cnt), 15);
        pulse_out();
        check("k_dec", int'(cnt), 14);

        // Re-raise from LOWER with timer restart
        do_reset();
        boat_here = 1'b1;
        tick(10);
        check("r_raise", int'(st), 3);
        br_up = 1'b1; tick(1); br_up = 1'b0; boat_here = 1'b0;
        tick(1);
        check("r_lower", int'(st), 5);
        tick(3);
        boat_here = 1'b1; br_down = 1'b1;
        tick(1);
        check("r_reraise", int'(st), 3);
        br_down = 1'b0;
        tick(31);
        check("r_timer_restart", int'(st), 3);
        tick(1);
        check("r_fault", int'(st), 6);

        // Sensor conflict in IDLE
        do_reset();
        br_up = 1'b1; br_down = 1'b1;
        tick(1);
        check("s_conflict", int'({st, fault}), {3'd6, 1'b1});

        // Async reset mid-RAISE
        do_reset();
        pulse_in();
        boat_close = 1'b1;
        tick(1);
        check("a_warn", int'(st), 1);
        tick(8);
        check("a_clear_wait", int'(st), 2);
        car_out = 1'b1; tick(1); car_out = 1'b0;
        tick(1);
        check("a_raise", int'({st, motor_up}), {3'd3, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check("a_motor_drop", int'(motor_up), 0);
        check("a_state0", int'(st), 0);
        boat_close = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("a_release", int'({st, cnt}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
